player_ctrl_param: RTL and testbench

- Parametrised, frame-paced player controller for the tile-grid game.
- Consumes controller buttons and a damage request. Produces the packed player and sword entity words, health, and status flags for the renderer and collision logic.
- Generalises grid size, coordinate width, health depth and timing.
- Adds over the first-generation controller: move cooldown, multi-frame attacks, edge-triggered attack, four-way orientation, invulnerability after damage, and a sticky dead state.

---
 rtl/player_ctrl_param_if.sv | 35 +++
 rtl/player_ctrl_param.sv | 204 ++++++++++++++++++++
 tb/tb_player_ctrl_param.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/player_ctrl_param_if.sv
// Bundle of the frame-paced player controller's game-side signals.
// The controller drives the entity words and flags; the game top drives buttons, tick and hit.
interface player_ctrl_param_if #(
  parameter int COORD_W  = 4,
  parameter int HEALTH_W = 2
);
  localparam int EW = 6 + 2 * COORD_W;

  // No valid/ready pairs here: frame_tick and hit are single-cycle strobes
  // sampled on every clk edge, buttons are levels, outputs are registered levels.
  logic                frame_tick;
  logic                up;
  logic                down;
  logic                left;
  logic                right;
  logic                A;
  logic                B;
  logic                hit;
  logic [EW-1:0]       player;
  logic [EW-1:0]       sword;
  logic [HEALTH_W-1:0] player_health;
  logic                attacking;
  logic                dead;
  logic [1:0]          state_dbg;

  modport master (
    output frame_tick, up, down, left, right, A, B, hit,
    input  player, sword, player_health, attacking, dead, state_dbg
  );

  modport slave (
    input  frame_tick, up, down, left, right, A, B, hit,
    output player, sword, player_health, attacking, dead, state_dbg
  );
endinterface

// File: rtl/player_ctrl_param.sv
// Tile-grid player controller: movement with cooldown, timed sword attacks,
// damage with invulnerability window and a sticky dead state.
module player_ctrl_param #(
  parameter int         GRID_W        = 16,
  parameter int         GRID_H        = 12,
  parameter int         COORD_W       = 4,
  parameter int         HEALTH_W      = 2,
  parameter int         MAX_HEALTH    = 3,
  parameter int         MOVE_COOLDOWN = 4,
  parameter int         ATTACK_FRAMES = 3,
  parameter int         INVULN_FRAMES = 8,
  parameter int         START_X       = 7,
  parameter int         START_Y       = 5,
  parameter logic [3:0] PLAYER_ID     = 4'd2,
  parameter logic [3:0] SWORD_ID      = 4'd1,
  parameter logic [3:0] HIDDEN_ID     = 4'hF
) (
  input logic               clk,
  input logic               reset,
  player_ctrl_param_if.slave bus
);

  localparam int EW   = 6 + 2 * COORD_W;
  localparam int MC_W = (MOVE_COOLDOWN > 2) ? $clog2(MOVE_COOLDOWN) : 1;
  localparam int AT_W = (ATTACK_FRAMES > 2) ? $clog2(ATTACK_FRAMES) : 1;
  localparam int IV_W = $clog2(INVULN_FRAMES + 1);

  localparam logic [COORD_W:0]    C_ONE    = (COORD_W+1)'(1);
  localparam logic [COORD_W:0]    GRID_W_C = (COORD_W+1)'(GRID_W);
  localparam logic [COORD_W:0]    GRID_H_C = (COORD_W+1)'(GRID_H);
  localparam logic [COORD_W-1:0]  X_RST    = COORD_W'(START_X);
  localparam logic [COORD_W-1:0]  Y_RST    = COORD_W'(START_Y);
  localparam logic [HEALTH_W-1:0] H_RST    = HEALTH_W'(MAX_HEALTH);
  localparam logic [HEALTH_W-1:0] H_ONE    = HEALTH_W'(1);
  localparam logic [MC_W-1:0]     MC_LOAD  = MC_W'(MOVE_COOLDOWN - 1);
  localparam logic [MC_W-1:0]     MC_ONE   = MC_W'(1);
  localparam logic [AT_W-1:0]     AT_LOAD  = AT_W'(ATTACK_FRAMES - 1);
  localparam logic [AT_W-1:0]     AT_ONE   = AT_W'(1);
  localparam logic [IV_W-1:0]     IV_LOAD  = IV_W'(INVULN_FRAMES);
  localparam logic [IV_W-1:0]     IV_ONE   = IV_W'(1);
  localparam logic [EW-1:0]       HIDDEN_W = {HIDDEN_ID, 2'b01, {(2*COORD_W){1'b0}}};

  localparam logic [1:0] O_UP    = 2'b00;
  localparam logic [1:0] O_RIGHT = 2'b01;
  localparam logic [1:0] O_DOWN  = 2'b10;
  localparam logic [1:0] O_LEFT  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ATTACK = 2'd1,
    ST_DEAD   = 2'd2
  } state_e;

  typedef struct packed {
    logic               ok;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } pos_t;

  // Neighbouring tile in direction o; ok is low when it would leave the grid.
  function automatic pos_t step_pos(input logic [1:0] o,
                                    input logic [COORD_W-1:0] px,
                                    input logic [COORD_W-1:0] py);
    logic [COORD_W:0] wx;
    logic [COORD_W:0] wy;
    pos_t             r;
    wx   = {1'b0, px};
    wy   = {1'b0, py};
    r.ok = 1'b1;
    case (o)
      O_UP:    begin r.ok = (py != '0); wy = wy - C_ONE; end
      O_RIGHT: begin wx = wx + C_ONE; r.ok = (wx < GRID_W_C); end
      O_DOWN:  begin wy = wy + C_ONE; r.ok = (wy < GRID_H_C); end
      default: begin r.ok = (px != '0); wx = wx - C_ONE; end
    endcase
    r.x = wx[COORD_W-1:0];
    r.y = wy[COORD_W-1:0];
    return r;
  endfunction

  state_e              state_q,    state_d;
  logic [COORD_W-1:0]  x_q,        x_d;
  logic [COORD_W-1:0]  y_q,        y_d;
  logic [1:0]          orient_q,   orient_d;
  logic [EW-1:0]       sword_q,    sword_d;
  logic [HEALTH_W-1:0] health_q,   health_d;
  logic [MC_W-1:0]     move_cnt_q, move_cnt_d;
  logic [AT_W-1:0]     atk_cnt_q,  atk_cnt_d;
  logic [IV_W-1:0]     inv_cnt_q,  inv_cnt_d;
  logic                ab_prev_q,  ab_prev_d;

  logic       ab_now;
  logic       atk_req;
  logic       dir_pressed;
  logic [1:0] dir_o;
  pos_t       mv;
  pos_t       ahead;

  always_comb begin
    ab_now      = bus.A | bus.B;
    atk_req     = ab_now & ~ab_prev_q;
    dir_pressed = bus.up | bus.down | bus.left | bus.right;
    if (bus.up)        dir_o = O_UP;
    else if (bus.down) dir_o = O_DOWN;
    else if (bus.left) dir_o = O_LEFT;
    else               dir_o = O_RIGHT;
    mv    = step_pos(dir_o, x_q, y_q);
    ahead = step_pos(orient_q, x_q, y_q);
  end

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    orient_d   = orient_q;
    sword_d    = sword_q;
    health_d   = health_q;
    move_cnt_d = move_cnt_q;
    atk_cnt_d  = atk_cnt_q;
    inv_cnt_d  = inv_cnt_q;
    ab_prev_d  = ab_prev_q;

    if (state_q != ST_DEAD) begin
      if (health_q == '0) begin
        // Death wins over whatever the tick would have done this cycle.
        state_d = ST_DEAD;
        sword_d = HIDDEN_W;
      end else begin
        if (bus.frame_tick) begin
          ab_prev_d = ab_now;
          if (inv_cnt_q != '0) inv_cnt_d = inv_cnt_q - IV_ONE;
          case (state_q)
            ST_IDLE: begin
              if (atk_req) begin
                state_d   = ST_ATTACK;
                atk_cnt_d = AT_LOAD;
                sword_d   = ahead.ok ? {SWORD_ID, orient_q, ahead.x, ahead.y} : HIDDEN_W;
              end else if (dir_pressed && move_cnt_q == '0) begin
                // Turning and the cooldown happen even against a wall.
                orient_d   = dir_o;
                move_cnt_d = MC_LOAD;
                if (mv.ok) begin
                  x_d = mv.x;
                  y_d = mv.y;
                end
              end else if (move_cnt_q != '0) begin
                move_cnt_d = move_cnt_q - MC_ONE;
              end
            end
            ST_ATTACK: begin
              if (move_cnt_q != '0) move_cnt_d = move_cnt_q - MC_ONE;
              if (atk_cnt_q == '0) begin
                state_d = ST_IDLE;
                sword_d = HIDDEN_W;
              end else begin
                atk_cnt_d = atk_cnt_q - AT_ONE;
              end
            end
            default: ;
          endcase
        end
        // health_q is nonzero on this path, so the decrement cannot wrap.
        if (bus.hit && inv_cnt_q == '0) begin
          health_d  = health_q - H_ONE;
          inv_cnt_d = IV_LOAD;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      x_q        <= X_RST;
      y_q        <= Y_RST;
      orient_q   <= O_RIGHT;
      sword_q    <= HIDDEN_W;
      health_q   <= H_RST;
      move_cnt_q <= '0;
      atk_cnt_q  <= '0;
      inv_cnt_q  <= '0;
      ab_prev_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      orient_q   <= orient_d;
      sword_q    <= sword_d;
      health_q   <= health_d;
      move_cnt_q <= move_cnt_d;
      atk_cnt_q  <= atk_cnt_d;
      inv_cnt_q  <= inv_cnt_d;
      ab_prev_q  <= ab_prev_d;
    end
  end

  assign bus.player        = {PLAYER_ID, orient_q, x_q, y_q};
  assign bus.sword         = sword_q;
  assign bus.player_health = health_q;
  assign bus.attacking     = (state_q == ST_ATTACK);
  assign bus.dead          = (state_q == ST_DEAD);
  assign bus.state_dbg     = state_q;

endmodule

// File: tb/tb_player_ctrl_param.sv
// Directed bench for player_ctrl_param: vector table for movement/attack,
// hand sequences for boundaries, damage, death and asynchronous reset.
module tb_player_ctrl_param;

  logic clk;
  logic reset;

  player_ctrl_param_if #(.COORD_W(4), .HEALTH_W(2)) bus();

  player_ctrl_param dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        t, u, d, l, r, a, b;
    logic [13:0] exp_p;
    logic [13:0] exp_s;
    logic        exp_att;
  } vec_t;

  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic logic [13:0] ent(input logic [3:0] id, input logic [1:0] o,
                                      input int x, input int y);
    return {id, o, 4'(x), 4'(y)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_p(input string n, input logic [13:0] e);
    check({n, " player"}, 32'(bus.player), 32'(e));
  endtask
  task automatic chk_s(input string n, input logic [13:0] e);
    check({n, " sword"}, 32'(bus.sword), 32'(e));
  endtask
  task automatic chk_h(input string n, input logic [1:0] e);
    check({n, " health"}, 32'(bus.player_health), 32'(e));
  endtask
  task automatic chk_att(input string n, input logic e);
    check({n, " attacking"}, 32'(bus.attacking), 32'(e));
  endtask
  task automatic chk_dead(input string n, input logic e);
    check({n, " dead"}, 32'(bus.dead), 32'(e));
  endtask

  task automatic drive(input logic t, input logic u, input logic d, input logic l,
                       input logic r, input logic a, input logic b, input logic h);
    @(negedge clk);
    bus.frame_tick = t;
    bus.up = u; bus.down = d; bus.left = l; bus.right = r;
    bus.A = a; bus.B = b; bus.hit = h;
    @(posedge clk);
    #1;
    bus.frame_tick = 1'b0;
    bus.hit = 1'b0;
  endtask

  task automatic ticks(input int n, input logic u, input logic d, input logic l,
                       input logic r, input logic a);
    repeat (n) drive(1'b1, u, d, l, r, a, 1'b0, 1'b0);
  endtask

  task automatic add(input logic t, input logic u, input logic d, input logic l,
                     input logic r, input logic a, input logic b,
                     input logic [13:0] p, input logic [13:0] s, input logic att);
    vec_t v;
    v.t = t; v.u = u; v.d = d; v.l = l; v.r = r; v.a = a; v.b = b;
    v.exp_p = p; v.exp_s = s; v.exp_att = att;
    vecs.push_back(v);
  endtask

  logic [13:0] hid;

  initial begin
    hid = 14'b1111_01_0000_0000;

    //   t  u  d  l  r  a  b   player              sword              att
    add(1, 0, 0, 0, 0, 0, 0, ent(2, 2'b01, 7, 5), hid,                0);
    add(1, 0, 0, 0, 0, 0, 0, ent(2, 2'b01, 7, 5), hid,                0);
    add(1, 0, 0, 0, 0, 0, 0, ent(2, 2'b01, 7, 5), hid,                0);
    add(1, 0, 0, 0, 1, 0, 0, ent(2, 2'b01, 8, 5), hid,                0);
    add(1, 0, 0, 0, 1, 0, 0, ent(2, 2'b01, 8, 5), hid,                0);
    add(1, 0, 0, 0, 1, 0, 0, ent(2, 2'b01, 8, 5), hid,                0);
    add(1, 0, 0, 0, 1, 0, 0, ent(2, 2'b01, 8, 5), hid,                0);
    add(1, 0, 0, 0, 1, 0, 0, ent(2, 2'b01, 9, 5), hid,                0);
    add(1, 0, 0, 0, 1, 0, 0, ent(2, 2'b01, 9, 5), hid,                0);
    add(1, 0, 0, 0, 1, 0, 0, ent(2, 2'b01, 9, 5), hid,                0);
    add(1, 0, 0, 0, 1, 0, 0, ent(2, 2'b01, 9, 5), hid,                0);
    add(1, 0, 0, 0, 0, 1, 0, ent(2, 2'b01, 9, 5), ent(1, 2'b01, 10, 5), 1);
    add(1, 0, 0, 0, 0, 1, 0, ent(2, 2'b01, 9, 5), ent(1, 2'b01, 10, 5), 1);
    add(1, 0, 0, 0, 0, 1, 0, ent(2, 2'b01, 9, 5), ent(1, 2'b01, 10, 5), 1);
    add(1, 0, 0, 0, 0, 1, 0, ent(2, 2'b01, 9, 5), hid,                0);
    add(1, 0, 0, 0, 0, 1, 0, ent(2, 2'b01, 9, 5), hid,                0);
    add(1, 0, 0, 0, 0, 0, 0, ent(2, 2'b01, 9, 5), hid,                0);
    add(1, 0, 0, 0, 0, 0, 1, ent(2, 2'b01, 9, 5), ent(1, 2'b01, 10, 5), 1);
    add(1, 0, 0, 0, 0, 0, 0, ent(2, 2'b01, 9, 5), ent(1, 2'b01, 10, 5), 1);
    add(1, 0, 0, 0, 0, 0, 0, ent(2, 2'b01, 9, 5), ent(1, 2'b01, 10, 5), 1);
    add(1, 0, 0, 0, 0, 0, 0, ent(2, 2'b01, 9, 5), hid,                0);
    add(1, 1, 0, 0, 0, 0, 0, ent(2, 2'b00, 9, 4), hid,                0);
    add(1, 1, 0, 0, 1, 0, 0, ent(2, 2'b00, 9, 4), hid,                0);
    add(0, 0, 0, 1, 0, 0, 0, ent(2, 2'b00, 9, 4), hid,                0);
    add(1, 0, 0, 1, 0, 0, 0, ent(2, 2'b00, 9, 4), hid,                0);
    add(1, 0, 0, 1, 0, 0, 0, ent(2, 2'b00, 9, 4), hid,                0);
    add(1, 0, 0, 1, 0, 0, 0, ent(2, 2'b11, 8, 4), hid,                0);
    add(1, 0, 0, 0, 0, 1, 0, ent(2, 2'b11, 8, 4), ent(1, 2'b11, 7, 4), 1);

    reset = 1'b1;
    bus.frame_tick = 0; bus.up = 0; bus.down = 0; bus.left = 0; bus.right = 0;
    bus.A = 0; bus.B = 0; bus.hit = 0;
    #12;
    chk_p("rst", ent(2, 2'b01, 7, 5));
    chk_s("rst", hid);
    chk_h("rst", 2'd3);
    chk_att("rst", 1'b0);
    chk_dead("rst", 1'b0);
    check("rst state_dbg", 32'(bus.state_dbg), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].t, vecs[i].u, vecs[i].d, vecs[i].l, vecs[i].r, vecs[i].a, vecs[i].b, 1'b0);
      chk_p($sformatf("vec%0d", i), vecs[i].exp_p);
      chk_s($sformatf("vec%0d", i), vecs[i].exp_s);
      chk_att($sformatf("vec%0d", i), vecs[i].exp_att);
    end
    chk_h("after table", 2'd3);

    // Walk to the top-left corner, then turn and cool down against the walls.
    ticks(40, 0, 0, 1, 0, 0);
    chk_p("left wall", ent(2, 2'b11, 0, 4));
    chk_att("left wall", 1'b0);
    ticks(30, 1, 0, 0, 0, 0);
    chk_p("top wall", ent(2, 2'b00, 0, 0));
    ticks(4, 0, 0, 0, 0, 0);
    ticks(1, 0, 0, 1, 0, 0);
    chk_p("blocked turn", ent(2, 2'b11, 0, 0));
    ticks(3, 0, 0, 0, 1, 0);
    chk_p("cooldown hold", ent(2, 2'b11, 0, 0));
    ticks(1, 0, 0, 0, 1, 0);
    chk_p("cooldown release", ent(2, 2'b01, 1, 0));
    ticks(4, 0, 0, 0, 0, 0);
    ticks(1, 1, 0, 0, 0, 0);
    chk_p("face up at top", ent(2, 2'b00, 1, 0));
    ticks(1, 0, 0, 0, 0, 1);
    chk_att("offgrid attack", 1'b1);
    chk_s("offgrid attack", hid);
    ticks(2, 0, 0, 0, 0, 0);
    chk_att("offgrid attack t+2", 1'b1);
    ticks(1, 0, 0, 0, 0, 0);
    chk_att("offgrid attack end", 1'b0);

    // Back-to-back hits inside the invulnerability window.
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    chk_h("triple hit", 2'd2);
    ticks(7, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    chk_h("hit inv=1", 2'd2);
    ticks(1, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    chk_h("hit inv=0", 2'd1);

    // Asynchronous reset in the middle of an attack.
    ticks(1, 0, 0, 0, 0, 1);
    chk_att("pre-reset attack", 1'b1);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #2 reset = 1'b1;
    #1;
    chk_p("async rst", ent(2, 2'b01, 7, 5));
    chk_s("async rst", hid);
    chk_h("async rst", 2'd3);
    chk_att("async rst", 1'b0);
    chk_dead("async rst", 1'b0);
    @(negedge clk);
    reset = 1'b0;

    // Hit on a tick: window loads full length, not one less.
    drive(1, 0, 0, 0, 0, 0, 0, 1);
    chk_h("hit on tick", 2'd2);
    ticks(7, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    chk_h("hit after 7 ticks", 2'd2);
    ticks(1, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    chk_h("second hit", 2'd1);
    ticks(9, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 1, 0, 1);
    chk_h("fatal hit", 2'd0);
    chk_att("fatal hit", 1'b1);
    chk_s("fatal hit", ent(1, 2'b01, 8, 5));
    chk_dead("fatal hit", 1'b0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk_dead("dead entry", 1'b1);
    chk_att("dead entry", 1'b0);
    chk_s("dead entry", hid);
    chk_h("dead entry", 2'd0);
    ticks(5, 1, 0, 0, 0, 1);
    ticks(5, 0, 0, 1, 0, 0);
    drive(1, 0, 0, 0, 0, 1, 0, 1);
    chk_p("dead frozen", ent(2, 2'b01, 7, 5));
    chk_s("dead frozen", hid);
    chk_att("dead frozen", 1'b0);
    chk_dead("dead frozen", 1'b1);
    check("dead state_dbg", 32'(bus.state_dbg), 32'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
